// File: rtl/intr_arbiter.sv
// External interrupt synchroniser, edge latch, mask/priority and req/ack/eret handshake to CP0.
// Build option: define INTR_LEVEL_TRIG_EN for level-triggered pending bits instead of rising-edge latching.
module intr_arbiter #(
  parameter int unsigned N_IRQ       = 2,
  parameter int unsigned ID_W        = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_gl,
  input  logic             rst,
  input  logic [N_IRQ-1:0] interrupt,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             int_en,
  input  logic             int_ack,
  input  logic             eret,
  output logic             int_req,
  output logic [ID_W-1:0]  int_id,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
  logic [N_IRQ-1:0] sync;
  logic [N_IRQ-1:0] pending_d;
  logic [N_IRQ-1:0] elig;
  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [ID_W-1:0]  id_d;
  logic [ID_W-1:0]  sel;
  logic             take;

  // Input synchronisers
  always_ff @(posedge clk_gl or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= interrupt;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign take = (state == REQ) && int_ack;

`ifdef INTR_LEVEL_TRIG_EN
  assign pending_d = sync;
`else
  logic [N_IRQ-1:0]     prev;
  logic [N_IRQ-1:0]     rise;
  logic [N_IRQ-1:0]     clr;
  logic [SYNC_STAGES:0] warm;

  // Edge history; warm holds off edge detection until prev holds a real post-reset sample,
  // so lines already high at reset release are not mistaken for new edges.
  always_ff @(posedge clk_gl or negedge rst) begin
    if (!rst) begin
      prev <= '0;
      warm <= '0;
    end else begin
      prev <= sync;
      warm <= {warm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign rise      = warm[SYNC_STAGES] ? (sync & ~prev) : '0;
  assign clr       = take ? (N_IRQ'(1) << int_id) : '0;
  // Set after clear: a new edge in the ack cycle is never lost
  assign pending_d = (pending & ~clr) | rise;
`endif

  assign elig = pending & ~irq_mask;

  // Lowest eligible index wins
  always_comb begin
    sel = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (elig[i]) sel = ID_W'(i);
    end
  end

  always_comb begin
    state_d = state;
    id_d    = int_id;
    case (state)
      IDLE: begin
        if (int_en && (|elig)) begin
          state_d = REQ;
          id_d    = sel;
        end
      end
      REQ: begin
        if (int_ack)                       state_d = SERVICE;
        else if (!int_en || !elig[int_id]) state_d = IDLE;
      end
      SERVICE: begin
        if (eret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_gl or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      int_id     <= '0;
      int_req    <= 1'b0;
      in_service <= 1'b0;
      pending    <= '0;
    end else begin
      state      <= state_d;
      int_id     <= id_d;
      int_req    <= (state_d == REQ);
      in_service <= (state_d == SERVICE);
      pending    <= pending_d;
    end
  end

endmodule

// File: tb/tb_intr_arbiter.sv
// Bench for intr_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_intr_arbiter;
  localparam int S = 2;
  localparam int N = 2;

  logic       clk_gl = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] interrupt = 2'b00;
  logic [1:0] irq_mask = 2'b00;
  logic       int_en = 1'b1;
  logic       int_ack = 1'b0;
  logic       eret = 1'b0;
  logic       int_req;
  logic [0:0] int_id;
  logic       in_service;
  logic [1:0] pending;

  int tests = 0;
  int fails = 0;
  int prints = 0;

  intr_arbiter #(.N_IRQ(N), .ID_W(1), .SYNC_STAGES(S)) dut (
    .clk_gl(clk_gl), .rst(rst), .interrupt(interrupt), .irq_mask(irq_mask),
    .int_en(int_en), .int_ack(int_ack), .eret(eret), .int_req(int_req),
    .int_id(int_id), .in_service(in_service), .pending(pending)
  );

  always #5 clk_gl = ~clk_gl;

  // Reference model: samples history, pending set, phase 0=idle 1=requesting 2=servicing
  logic [1:0] hist [0:S];
  int         n_edges = 0;
  int         ph = 0;
  int         nph;
  logic [1:0] m_pend = 2'b00;
  logic [0:0] m_id = 1'b0;
  logic [1:0] m_rise, m_el, m_clr;

  function automatic int lowest(input logic [1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk_gl or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k <= S; k++) hist[k] = 2'b00;
      n_edges = 0; ph = 0; m_pend = 2'b00; m_id = 1'b0;
    end else begin
      m_rise = (n_edges > S) ? (hist[S-1] & ~hist[S]) : 2'b00;
      m_el   = m_pend & ~irq_mask;
      m_clr  = 2'b00;
      nph    = ph;
      if (ph == 0) begin
        if (int_en && m_el != 2'b00) begin nph = 1; m_id = 1'(lowest(m_el)); end
      end else if (ph == 1) begin
        if (int_ack) begin nph = 2; m_clr[m_id] = 1'b1; end
        else if (!int_en || irq_mask[m_id]) nph = 0;
      end else begin
        if (eret) nph = 0;
      end
      m_pend = (m_pend & ~m_clr) | m_rise;
      ph = nph;
      for (int k = S; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = interrupt;
      if (n_edges < 1000) n_edges++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_gl);
  endtask

  task automatic test_reset;
    rst = 1'b0; interrupt = 2'b11;
    repeat (25) begin
      @(negedge clk_gl);
      tests++;
      if (int_req !== 1'b0 || pending !== 2'b00 || in_service !== 1'b0 || int_id !== 1'b0) begin
        fails++; $display("FAIL reset_hold: req=%b pend=%b svc=%b id=%b, want 0/00/0/0", int_req, pending, in_service, int_id);
      end
    end
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk_gl);
      tests++;
      if (int_req !== 1'b0 || pending !== 2'b00) begin
        fails++; $display("FAIL reset_release_no_req: req=%b pend=%b, want 0/00", int_req, pending);
      end
    end
    interrupt = 2'b00; tick(5);
  endtask

  task automatic test_single;
    interrupt = 2'b10; tick(3);
    tests++;
    if (pending !== 2'b10 || int_req !== 1'b0) begin
      fails++; $display("FAIL single_pend: pend=%b req=%b, want 10/0", pending, int_req);
    end
    tick(1);
    tests++;
    if (int_req !== 1'b1 || int_id !== 1'b1) begin
      fails++; $display("FAIL single_req: req=%b id=%b, want 1/1", int_req, int_id);
    end
    int_ack = 1'b1; interrupt = 2'b00; tick(1); int_ack = 1'b0;
    tests++;
    if (in_service !== 1'b1 || int_req !== 1'b0 || pending !== 2'b00) begin
      fails++; $display("FAIL single_ack: svc=%b req=%b pend=%b, want 1/0/00", in_service, int_req, pending);
    end
    eret = 1'b1; tick(1); eret = 1'b0;
    tests++;
    if (in_service !== 1'b0 || int_req !== 1'b0) begin
      fails++; $display("FAIL single_eret: svc=%b req=%b, want 0/0", in_service, int_req);
    end
    tick(3);
    tests++;
    if (int_req !== 1'b0) begin
      fails++; $display("FAIL single_quiet: req=%b, want 0", int_req);
    end
  endtask

  task automatic test_priority;
    interrupt = 2'b11; tick(4);
    tests++;
    if (int_req !== 1'b1 || int_id !== 1'b0 || pending !== 2'b11) begin
      fails++; $display("FAIL prio_first: req=%b id=%b pend=%b, want 1/0/11", int_req, int_id, pending);
    end
    int_ack = 1'b1; tick(1); int_ack = 1'b0;
    tests++;
    if (in_service !== 1'b1 || pending !== 2'b10) begin
      fails++; $display("FAIL prio_ack: svc=%b pend=%b, want 1/10", in_service, pending);
    end
    eret = 1'b1; tick(1); eret = 1'b0;
    tests++;
    if (int_req !== 1'b0 || in_service !== 1'b0) begin
      fails++; $display("FAIL prio_gap: req=%b svc=%b, want 0/0", int_req, in_service);
    end
    tick(1);
    tests++;
    if (int_req !== 1'b1 || int_id !== 1'b1) begin
      fails++; $display("FAIL prio_second: req=%b id=%b, want 1/1", int_req, int_id);
    end
    int_ack = 1'b1; interrupt = 2'b00; tick(1); int_ack = 1'b0;
    eret = 1'b1; tick(1); eret = 1'b0; tick(2);
  endtask

  task automatic test_mask_enable;
    irq_mask = 2'b01; interrupt = 2'b01; tick(6);
    tests++;
    if (int_req !== 1'b0 || pending !== 2'b01) begin
      fails++; $display("FAIL mask_hold: req=%b pend=%b, want 0/01", int_req, pending);
    end
    irq_mask = 2'b00; tick(1);
    tests++;
    if (int_req !== 1'b1 || int_id !== 1'b0) begin
      fails++; $display("FAIL mask_release: req=%b id=%b, want 1/0", int_req, int_id);
    end
    int_en = 1'b0; tick(1);
    tests++;
    if (int_req !== 1'b0 || pending !== 2'b01) begin
      fails++; $display("FAIL en_withdraw: req=%b pend=%b, want 0/01", int_req, pending);
    end
    int_en = 1'b1; tick(1);
    tests++;
    if (int_req !== 1'b1 || int_id !== 1'b0) begin
      fails++; $display("FAIL en_restore: req=%b id=%b, want 1/0", int_req, int_id);
    end
    irq_mask = 2'b01; tick(1);
    tests++;
    if (int_req !== 1'b0 || pending !== 2'b01) begin
      fails++; $display("FAIL mask_withdraw: req=%b pend=%b, want 0/01", int_req, pending);
    end
    irq_mask = 2'b00; tick(1);
    int_ack = 1'b1; interrupt = 2'b00; tick(1); int_ack = 1'b0;
    eret = 1'b1; tick(1); eret = 1'b0; tick(2);
  endtask

  task automatic test_service_edge;
    interrupt = 2'b01; tick(4);
    int_ack = 1'b1; tick(1); int_ack = 1'b0;
    tests++;
    if (in_service !== 1'b1 || int_req !== 1'b0) begin
      fails++; $display("FAIL svc_enter: svc=%b req=%b, want 1/0", in_service, int_req);
    end
    interrupt = 2'b11; tick(4);
    tests++;
    if (pending !== 2'b10 || int_req !== 1'b0 || in_service !== 1'b1) begin
      fails++; $display("FAIL svc_edge_pend: pend=%b req=%b svc=%b, want 10/0/1", pending, int_req, in_service);
    end
    int_ack = 1'b1; tick(1); int_ack = 1'b0;
    tests++;
    if (in_service !== 1'b1 || pending !== 2'b10) begin
      fails++; $display("FAIL svc_ignore_ack: svc=%b pend=%b, want 1/10", in_service, pending);
    end
    eret = 1'b1; tick(1); eret = 1'b0; tick(1);
    tests++;
    if (int_req !== 1'b1 || int_id !== 1'b1) begin
      fails++; $display("FAIL svc_after_eret: req=%b id=%b, want 1/1", int_req, int_id);
    end
    int_ack = 1'b1; interrupt = 2'b00; tick(1); int_ack = 1'b0;
    eret = 1'b1; tick(1); eret = 1'b0; tick(3);
    // Edge on line 0 lands in the same cycle as the ack of ID 0
    interrupt = 2'b01; tick(4);
    interrupt = 2'b00; tick(4);
    tests++;
    if (int_req !== 1'b1 || int_id !== 1'b0) begin
      fails++; $display("FAIL set_wins_setup: req=%b id=%b, want 1/0", int_req, int_id);
    end
    interrupt = 2'b01; tick(2);
    int_ack = 1'b1; tick(1); int_ack = 1'b0;
    tests++;
    if (in_service !== 1'b1 || pending !== 2'b01) begin
      fails++; $display("FAIL set_wins: svc=%b pend=%b, want 1/01", in_service, pending);
    end
    eret = 1'b1; tick(1); eret = 1'b0; tick(1);
    tests++;
    if (int_req !== 1'b1 || int_id !== 1'b0) begin
      fails++; $display("FAIL set_wins_rereq: req=%b id=%b, want 1/0", int_req, int_id);
    end
    int_ack = 1'b1; interrupt = 2'b00; tick(1); int_ack = 1'b0;
    eret = 1'b1; tick(1); eret = 1'b0; tick(3);
  endtask

  task automatic test_async_reset;
    interrupt = 2'b10; tick(4);
    int_ack = 1'b1; tick(1); int_ack = 1'b0;
    interrupt = 2'b11; tick(4);
    tests++;
    if (in_service !== 1'b1 || pending !== 2'b01 || int_id !== 1'b1) begin
      fails++; $display("FAIL arst_pre: svc=%b pend=%b id=%b, want 1/01/1", in_service, pending, int_id);
    end
    @(posedge clk_gl); #3 rst = 1'b0; #1;
    tests++;
    if (int_req !== 1'b0 || in_service !== 1'b0 || pending !== 2'b00 || int_id !== 1'b0) begin
      fails++; $display("FAIL arst_now: req=%b svc=%b pend=%b id=%b, want all 0", int_req, in_service, pending, int_id);
    end
    #2 rst = 1'b1;
    repeat (10) begin
      @(negedge clk_gl);
      tests++;
      if (int_req !== 1'b0 || in_service !== 1'b0 || pending !== 2'b00) begin
        fails++; $display("FAIL arst_after: req=%b svc=%b pend=%b, want 0/0/00", int_req, in_service, pending);
      end
    end
    interrupt = 2'b00; tick(5);
  endtask

  task automatic test_random;
    repeat (1500) begin
      @(negedge clk_gl);
      tests++;
      if (int_req !== (ph == 1) || in_service !== (ph == 2) || pending !== m_pend || int_id !== m_id) begin
        fails++;
        if (prints < 10) begin
          prints++;
          $display("FAIL random: req=%b svc=%b pend=%b id=%b, want %b/%b/%b/%b",
                   int_req, in_service, pending, int_id, (ph == 1), (ph == 2), m_pend, m_id);
        end
      end
      if ($urandom_range(0, 5) == 0) interrupt[0] = ~interrupt[0];
      if ($urandom_range(0, 5) == 0) interrupt[1] = ~interrupt[1];
      if ($urandom_range(0, 19) == 0) irq_mask = 2'($urandom_range(0, 3));
      int_en  = ($urandom_range(0, 9) != 0);
      int_ack = ($urandom_range(0, 2) == 0);
      eret    = ($urandom_range(0, 3) == 0);
    end
    int_ack = 1'b0; eret = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask_enable();
    test_service_edge();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
